// File: rtl/maze_player_core.sv
// maze_player_core
// Player-motion and scoring engine for the maze game. Owns the player pixel
// position, heading, visited-cell map, food score, elapsed-seconds counter and
// end-of-game detection for a COLS x ROWS grid of 2^CELL_LOG2-pixel cells.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset (clears final_score)
//   restart             pulse: start a new game, final_score is kept
//   enable              movement grant; tick and state advance only when high
//   btn[3:0]            turn requests: 0 right, 1 down, 2 left, 3 up
//   h_walls             top wall of cell (c,r) at bit r*COLS+c
//   v_walls             left wall of cell (c,r) at bit r*(COLS+1)+c
//   food                2-bit food class of cell (c,r) at bits 2*(r*COLS+c)
//   pos_x, pos_y        player pixel position
//   direction, moving   current heading; player advances on next tick
//   score, seconds      running score (saturating), elapsed seconds (saturating)
//   final_score, done   result of last finished game; game-over flag
//
// Build option: define MAZE_CORE_TIME_PENALTY_EN to subtract the elapsed
// seconds from the final score (clamped at zero).

module maze_player_core #(
    parameter int COLS         = 10,
    parameter int ROWS         = 15,
    parameter int CELL_LOG2    = 5,
    parameter int SPEED_FACTOR = 32,
    parameter int FREQUENCY    = 50000000,
    parameter int COST0        = 1,
    parameter int COST1        = 4,
    parameter int COST2        = 16,
    parameter int COST3        = 64,
    parameter int SCORE_W      = 16,
    localparam int XW          = $clog2(COLS) + CELL_LOG2,
    localparam int YW          = $clog2(ROWS) + CELL_LOG2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       restart,
    input  logic                       enable,
    input  logic [3:0]                 btn,
    input  logic [(ROWS+1)*COLS-1:0]   h_walls,
    input  logic [ROWS*(COLS+1)-1:0]   v_walls,
    input  logic [2*ROWS*COLS-1:0]     food,
    output logic [XW-1:0]              pos_x,
    output logic [YW-1:0]              pos_y,
    output logic [1:0]                 direction,
    output logic                       moving,
    output logic [SCORE_W-1:0]         score,
    output logic [15:0]                seconds,
    output logic [SCORE_W-1:0]         final_score,
    output logic                       done
);

    localparam int NCELL = ROWS * COLS;
    localparam int TW    = $clog2(SPEED_FACTOR);
    localparam int PW    = $clog2(FREQUENCY);

    typedef enum logic [1:0] {StIdle, StDecide, StMove, StDone} state_t;

    state_t               state_q, state_d;
    logic [XW-1:0]        pos_x_q, pos_x_d;
    logic [YW-1:0]        pos_y_q, pos_y_d;
    logic [1:0]           dir_q, dir_d;
    logic                 moving_q, moving_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [15:0]          seconds_q, seconds_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [NCELL-1:0]     visited_q, visited_d;
    logic [1:0]           pend_q, pend_d;
    logic                 pend_valid_q, pend_valid_d;
    logic                 done_q, done_d;
    logic [SCORE_W-1:0]   final_q, final_d;

    // Current-cell decode
    int unsigned          cx, cy, cidx, vidx;
    logic [3:0]           free_dir;
    logic [1:0]           food_class;
    logic [31:0]          cost;
    logic [SCORE_W+32:0]  sum;
    logic [SCORE_W-1:0]   score_sat;
    logic [NCELL-1:0]     cell_bit;
    logic [XW-1:0]        step_x;
    logic [YW-1:0]        step_y;
    logic                 step_aligned;
    logic [1:0]           btn_low;

    always_comb begin
        cx   = 32'(pos_x_q >> CELL_LOG2);
        cy   = 32'(pos_y_q >> CELL_LOG2);
        cidx = cy * COLS + cx;
        vidx = cy * (COLS + 1) + cx;
        // A side is open only if its wall bit is clear and a neighbour exists
        free_dir[0] = !1'(v_walls >> (vidx + 1)) && (cx < COLS - 1);
        free_dir[1] = !1'(h_walls >> (cidx + COLS)) && (cy < ROWS - 1);
        free_dir[2] = !1'(v_walls >> vidx) && (cx > 0);
        free_dir[3] = !1'(h_walls >> cidx) && (cy > 0);
        food_class  = 2'(food >> (2 * cidx));
        cell_bit    = {{(NCELL-1){1'b0}}, 1'b1} << cidx;
    end

    always_comb begin
        case (food_class)
            2'd0:    cost = 32'(COST0);
            2'd1:    cost = 32'(COST1);
            2'd2:    cost = 32'(COST2);
            default: cost = 32'(COST3);
        endcase
        sum = (SCORE_W+33)'(score_q) + (SCORE_W+33)'(cost);
        // Any carry into the upper bits means the score would overflow
        if (sum[SCORE_W+32:SCORE_W] != '0) begin
            score_sat = '1;
        end else begin
            score_sat = sum[SCORE_W-1:0];
        end
    end

    always_comb begin
        step_x = pos_x_q;
        step_y = pos_y_q;
        case (dir_q)
            2'd0:    step_x = pos_x_q + XW'(1);
            2'd1:    step_y = pos_y_q + YW'(1);
            2'd2:    step_x = pos_x_q - XW'(1);
            default: step_y = pos_y_q - YW'(1);
        endcase
        step_aligned = (step_x[CELL_LOG2-1:0] == '0) && (step_y[CELL_LOG2-1:0] == '0);
        if (btn[0]) begin
            btn_low = 2'd0;
        end else if (btn[1]) begin
            btn_low = 2'd1;
        end else if (btn[2]) begin
            btn_low = 2'd2;
        end else begin
            btn_low = 2'd3;
        end
    end

    always_comb begin
        state_d      = state_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        dir_d        = dir_q;
        moving_d     = moving_q;
        score_d      = score_q;
        seconds_d    = seconds_q;
        presc_d      = presc_q;
        tick_d       = tick_q;
        visited_d    = visited_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        done_d       = done_q;
        final_d      = final_q;

        // Wall-clock time runs while a game is in progress, regardless of enable
        if (state_q == StDecide || state_q == StMove) begin
            if (presc_q == PW'(FREQUENCY - 1)) begin
                presc_d = '0;
                if (seconds_q != 16'hFFFF) begin
                    seconds_d = seconds_q + 16'd1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StDecide;
                end
            end
            StDecide: begin
                if (enable) begin
                    if ((visited_q & cell_bit) == '0) begin
                        score_d = score_sat;
                    end
                    visited_d = visited_q | cell_bit;
                    if (&(visited_q | cell_bit)) begin
                        state_d  = StDone;
                        moving_d = 1'b0;
                    end else begin
                        if (pend_valid_q && free_dir[pend_q]) begin
                            dir_d        = pend_q;
                            moving_d     = 1'b1;
                            pend_valid_d = 1'b0;
                        end else begin
                            moving_d = free_dir[dir_q];
                        end
                        state_d = StMove;
                    end
                end
            end
            StMove: begin
                if (enable) begin
                    if (tick_q == TW'(SPEED_FACTOR - 1)) begin
                        tick_d = '0;
                        if (moving_q) begin
                            pos_x_d = step_x;
                            pos_y_d = step_y;
                        end
                        if (!moving_q || step_aligned) begin
                            state_d = StDecide;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: begin
                done_d = 1'b1;
`ifdef MAZE_CORE_TIME_PENALTY_EN
                if (32'(seconds_q) > 32'(score_q)) begin
                    final_d = '0;
                end else begin
                    final_d = SCORE_W'(32'(score_q) - 32'(seconds_q));
                end
`else
                final_d = score_q;
`endif
            end
        endcase

        // A press in the decision cycle re-arms the request after consumption
        if (state_q != StDone && btn != 4'd0) begin
            pend_d       = btn_low;
            pend_valid_d = 1'b1;
        end

        if (restart) begin
            state_d      = StIdle;
            pos_x_d      = '0;
            pos_y_d      = '0;
            dir_d        = 2'd2;
            moving_d     = 1'b0;
            score_d      = '0;
            seconds_d    = '0;
            presc_d      = '0;
            tick_d       = '0;
            visited_d    = '0;
            pend_d       = '0;
            pend_valid_d = 1'b0;
            done_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            dir_q        <= 2'd2;
            moving_q     <= 1'b0;
            score_q      <= '0;
            seconds_q    <= '0;
            presc_q      <= '0;
            tick_q       <= '0;
            visited_q    <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            done_q       <= 1'b0;
            final_q      <= '0;
        end else begin
            state_q      <= state_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            dir_q        <= dir_d;
            moving_q     <= moving_d;
            score_q      <= score_d;
            seconds_q    <= seconds_d;
            presc_q      <= presc_d;
            tick_q       <= tick_d;
            visited_q    <= visited_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            done_q       <= done_d;
            final_q      <= final_d;
        end
    end

    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign direction   = dir_q;
    assign moving      = moving_q;
    assign score       = score_q;
    assign seconds     = seconds_q;
    assign final_score = final_q;
    assign done        = done_q;

endmodule

// File: tb/tb_maze_player_core.sv
// Testbench for maze_player_core on a 3x2 grid of 2-pixel cells. Random games
// (random walls, food, enable, turn presses, restarts and resets) are played
// against a game-level reference model; each cycle's expected outputs are
// queued and a separate monitor compares them against the DUT.

module tb_maze_player_core;

    localparam int COLS  = 3;
    localparam int ROWS  = 2;
    localparam int CL    = 1;
    localparam int SF    = 2;
    localparam int FREQ  = 10;
    localparam int SW    = 8;
    localparam int XW    = $clog2(COLS) + CL;
    localparam int YW    = $clog2(ROWS) + CL;
    localparam int NC    = ROWS * COLS;
    localparam int HW    = (ROWS + 1) * COLS;
    localparam int VW    = ROWS * (COLS + 1);
    localparam int FW    = 2 * NC;

    logic          clk = 1'b0;
    logic          rst;
    logic          restart;
    logic          enable;
    logic [3:0]    btn;
    logic [HW-1:0] h_walls;
    logic [VW-1:0] v_walls;
    logic [FW-1:0] food;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic [1:0]    direction;
    logic          moving;
    logic [SW-1:0] score;
    logic [15:0]   seconds;
    logic [SW-1:0] final_score;
    logic          done;

    maze_player_core #(
        .COLS(COLS), .ROWS(ROWS), .CELL_LOG2(CL), .SPEED_FACTOR(SF),
        .FREQUENCY(FREQ), .COST0(1), .COST1(4), .COST2(16), .COST3(64), .SCORE_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .restart(restart), .enable(enable), .btn(btn),
        .h_walls(h_walls), .v_walls(v_walls), .food(food),
        .pos_x(pos_x), .pos_y(pos_y), .direction(direction), .moving(moving),
        .score(score), .seconds(seconds), .final_score(final_score), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int px; int py; int dir; int mv; int sc; int sec; int dn; int fin;
    } snap_t;

    snap_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    // Reference model: player as pixel coordinates plus a countdown of enabled
    // cycles until the next cell decision.
    int            m_phase;   // 0 waiting for start, 1 playing, 2 game over
    int            m_wait;
    int            m_px, m_py, m_dir, m_moving, m_score, m_active;
    int            m_pend, m_pend_v, m_done, m_final;
    logic [NC-1:0] m_vis;

    task automatic m_new_game();
        m_phase = 0; m_wait = 0; m_px = 0; m_py = 0; m_dir = 2; m_moving = 0;
        m_score = 0; m_active = 0; m_pend = 0; m_pend_v = 0; m_done = 0;
        m_vis = '0;
    endtask

    function automatic bit m_free(int c, int r, int d);
        case (d)
            0:       return (c < COLS - 1) && !1'(v_walls >> (r * (COLS + 1) + c + 1));
            1:       return (r < ROWS - 1) && !1'(h_walls >> ((r + 1) * COLS + c));
            2:       return (c > 0) && !1'(v_walls >> (r * (COLS + 1) + c));
            default: return (r > 0) && !1'(h_walls >> (r * COLS + c));
        endcase
    endfunction

    function automatic int m_cost(int cls);
        case (cls)
            0:       return 1;
            1:       return 4;
            2:       return 16;
            default: return 64;
        endcase
    endfunction

    function automatic int m_seconds();
        int s;
        s = m_active / FREQ;
        return (s > 65535) ? 65535 : s;
    endfunction

    task automatic model_step();
        int c, r, idx, lo, smax;
        smax = (1 << SW) - 1;
        if (!rst) begin
            m_new_game();
            m_final = 0;
            return;
        end
        if (restart) begin
            m_new_game();
            return;
        end
        if (m_phase == 2) begin
            m_done = 1;
`ifdef MAZE_CORE_TIME_PENALTY_EN
            m_final = (m_seconds() > m_score) ? 0 : m_score - m_seconds();
`else
            m_final = m_score;
`endif
            return;
        end
        lo = btn[0] ? 0 : btn[1] ? 1 : btn[2] ? 2 : btn[3] ? 3 : -1;
        if (m_phase == 1) m_active++;
        if (m_phase == 0) begin
            if (enable) m_phase = 1;
        end else if (enable) begin
            if (m_wait == 0) begin
                c = m_px >> CL;
                r = m_py >> CL;
                idx = r * COLS + c;
                if (!1'(m_vis >> idx)) begin
                    m_vis = m_vis | (NC'(1) << idx);
                    m_score = m_score + m_cost(int'(2'(food >> (2 * idx))));
                    if (m_score > smax) m_score = smax;
                end
                if (&m_vis) begin
                    m_phase = 2;
                    m_moving = 0;
                end else begin
                    if (m_pend_v != 0 && m_free(c, r, m_pend)) begin
                        m_dir = m_pend;
                        m_moving = 1;
                        m_pend_v = 0;
                    end else begin
                        m_moving = m_free(c, r, m_dir) ? 1 : 0;
                    end
                    m_wait = SF;
                end
            end else begin
                m_wait--;
                if (m_wait == 0 && m_moving != 0) begin
                    case (m_dir)
                        0:       m_px++;
                        1:       m_py++;
                        2:       m_px--;
                        default: m_py--;
                    endcase
                    // Mid-cell: keep stepping; at a cell boundary: decide next
                    if ((m_px % (1 << CL)) != 0 || (m_py % (1 << CL)) != 0) m_wait = SF;
                end
            end
        end
        if (lo >= 0) begin
            m_pend = lo;
            m_pend_v = 1;
        end
    endtask

    function automatic snap_t m_snap();
        snap_t s;
        s.px = m_px; s.py = m_py; s.dir = m_dir; s.mv = m_moving; s.sc = m_score;
        s.sec = m_seconds(); s.dn = m_done; s.fin = m_final;
        return s;
    endfunction

    // Monitor: outputs are registered, so compare on the falling edge
    always @(negedge clk) begin
        snap_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (int'(pos_x) != e.px || int'(pos_y) != e.py || int'(direction) != e.dir ||
                int'(moving) != e.mv || int'(score) != e.sc || int'(seconds) != e.sec ||
                int'(done) != e.dn || int'(final_score) != e.fin) begin
                failures++;
                $display("FAIL outputs t=%0t got px=%0d py=%0d dir=%0d mv=%0d score=%0d sec=%0d done=%0d final=%0d required px=%0d py=%0d dir=%0d mv=%0d score=%0d sec=%0d done=%0d final=%0d",
                         $time, pos_x, pos_y, direction, moving, score, seconds, done,
                         final_score, e.px, e.py, e.dir, e.mv, e.sc, e.sec, e.dn, e.fin);
            end
        end
    end

    // Watchdog: the run must finish well within this bound
    initial begin
        #10000000;
        failures++;
        $display("FAIL timeout: run did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic cycle();
        @(posedge clk);
        model_step();
        exp_q.push_back(m_snap());
        @(negedge clk);
    endtask

    task automatic new_maze(int g);
        h_walls = '0;
        v_walls = '0;
        if (g % 3 != 0) begin
            for (int k = 0; k < HW; k++) if ($urandom_range(0, 3) == 0) h_walls ^= HW'(1) << k;
            for (int k = 0; k < VW; k++) if ($urandom_range(0, 3) == 0) v_walls ^= VW'(1) << k;
        end
        food = (g == 1) ? '1 : FW'($urandom);
    endtask

    initial begin
        rst = 1'b0; restart = 1'b0; enable = 1'b0; btn = 4'd0;
        h_walls = '0; v_walls = '0; food = '0;
        m_new_game();
        m_final = 0;
        @(negedge clk);
        for (int g = 0; g < 12; g++) begin
            new_maze(g);
            if (g == 0 || g == 7) begin
                rst = 1'b0;
                cycle();
                cycle();
                checks++;
                if (pos_x != '0 || pos_y != '0 || direction != 2'd2 || moving != 1'b0 ||
                    score != '0 || seconds != 16'd0 || done != 1'b0 || final_score != '0) begin
                    failures++;
                    $display("FAIL reset state t=%0t px=%0d py=%0d dir=%0d mv=%0d score=%0d sec=%0d done=%0d final=%0d",
                             $time, pos_x, pos_y, direction, moving, score, seconds, done,
                             final_score);
                end
                rst = 1'b1;
            end else begin
                restart = 1'b1;
                cycle();
                restart = 1'b0;
            end
            for (int t = 0; t < 500; t++) begin
                enable = ($urandom_range(0, 3) != 0);
                btn = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                if ($urandom_range(0, 199) == 0) v_walls ^= VW'(1) << $urandom_range(0, VW - 1);
                if ($urandom_range(0, 199) == 0) h_walls ^= HW'(1) << $urandom_range(0, HW - 1);
                restart = ($urandom_range(0, 399) == 0);
                cycle();
                restart = 1'b0;
            end
        end
        btn = 4'd0;
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
